// File: rtl/add_sub_man_align.sv
// Mantissa alignment stage of the FPU add/sub datapath: right-shifts the smaller
// mantissa by the exponent difference and appends guard/round/sticky bits.
module add_sub_man_align #(
    parameter int SIZE_MAN = 24,
    parameter int SIZE_EXP = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE_MAN-1:0]   i_man_min,
    input  logic [SIZE_MAN-1:0]   i_man_max,
    input  logic [SIZE_EXP-1:0]   i_exp_diff,
    input  logic [SIZE_EXP-1:0]   i_exp_max,
    input  logic                  i_sign,
    input  logic                  i_eff_sub,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_MAN+2:0]   o_man_max,
    output logic [SIZE_MAN+2:0]   o_man_min,
    output logic [SIZE_EXP-1:0]   o_exp_max,
    output logic                  o_sign,
    output logic                  o_eff_sub
);

    localparam int          W   = SIZE_MAN + 3;
    localparam logic [31:0] W_U = 32'(W);

    // OR of the bits of val that a right shift by amt pushes out.
    function automatic logic lost_or(input logic [W-1:0] val, input logic [31:0] amt);
        logic [W-1:0] mask;
        mask = ~({W{1'b1}} << amt);
        return |(val & mask);
    endfunction

    // Right shift that folds every shifted-out bit into the sticky position.
    function automatic logic [W-1:0] shift_sticky(input logic [W-1:0] val, input logic [31:0] amt);
        logic [W-1:0] res;
        res    = val >> amt;
        res[0] = res[0] | lost_or(val, amt);
        return res;
    endfunction

    logic                adv1_s, adv2_s;
    logic [W-1:0]        ext_man_s, s1_man_d_s, s2_man_d_s;
    logic [SIZE_EXP-1:0] coarse_s;
    logic                sat_s;

    logic                s1_valid_r, s1_sat_r, s1_sign_r, s1_eff_sub_r;
    logic [1:0]          s1_fine_r;
    logic [W-1:0]        s1_man_min_r, s1_man_max_r;
    logic [SIZE_EXP-1:0] s1_exp_max_r;

    logic                s2_valid_r, s2_sign_r, s2_eff_sub_r;
    logic [W-1:0]        s2_man_min_r, s2_man_max_r;
    logic [SIZE_EXP-1:0] s2_exp_max_r;

    // Stall logic: a stage advances when it is empty or the stage below advances.
    always_comb begin
        adv2_s  = ~s2_valid_r | i_ready;
        adv1_s  = ~s1_valid_r | adv2_s;
        o_ready = adv1_s;
    end

    // Coarse shift by a multiple of 4; shifts of W or more collapse to a lone sticky bit.
    always_comb begin
        ext_man_s = {i_man_min, 3'b000};
        coarse_s  = {i_exp_diff[SIZE_EXP-1:2], 2'b00};
        sat_s     = (32'(i_exp_diff) >= W_U);
        if (sat_s) begin
            s1_man_d_s = {{(W-1){1'b0}}, |i_man_min};
        end else begin
            s1_man_d_s = shift_sticky(ext_man_s, 32'(coarse_s));
        end
    end

    // Residual shift of 0-3; the coarse sticky already sits in bit 0 and is re-folded.
    always_comb begin
        if (s1_sat_r) begin
            s2_man_d_s = s1_man_min_r;
        end else begin
            s2_man_d_s = shift_sticky(s1_man_min_r, 32'(s1_fine_r));
        end
    end

    // Stage 1 registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_sat_r     <= 1'b0;
            s1_fine_r    <= 2'b00;
            s1_man_min_r <= {W{1'b0}};
            s1_man_max_r <= {W{1'b0}};
            s1_exp_max_r <= {SIZE_EXP{1'b0}};
            s1_sign_r    <= 1'b0;
            s1_eff_sub_r <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= i_valid;
            if (i_valid) begin
                s1_sat_r     <= sat_s;
                s1_fine_r    <= i_exp_diff[1:0];
                s1_man_min_r <= s1_man_d_s;
                s1_man_max_r <= {i_man_max, 3'b000};
                s1_exp_max_r <= i_exp_max;
                s1_sign_r    <= i_sign;
                s1_eff_sub_r <= i_eff_sub;
            end
        end
    end

    // Stage 2 registers drive the outputs directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_r   <= 1'b0;
            s2_man_min_r <= {W{1'b0}};
            s2_man_max_r <= {W{1'b0}};
            s2_exp_max_r <= {SIZE_EXP{1'b0}};
            s2_sign_r    <= 1'b0;
            s2_eff_sub_r <= 1'b0;
        end else if (adv2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_man_min_r <= s2_man_d_s;
                s2_man_max_r <= s1_man_max_r;
                s2_exp_max_r <= s1_exp_max_r;
                s2_sign_r    <= s1_sign_r;
                s2_eff_sub_r <= s1_eff_sub_r;
            end
        end
    end

    assign o_valid   = s2_valid_r;
    assign o_man_min = s2_man_min_r;
    assign o_man_max = s2_man_max_r;
    assign o_exp_max = s2_exp_max_r;
    assign o_sign    = s2_sign_r;
    assign o_eff_sub = s2_eff_sub_r;

endmodule

// File: tb/tb_add_sub_man_align.sv
// Self-checking bench for add_sub_man_align: directed vector table, streaming,
// stall, reset and randomized handshake sequences against a reference model.
module tb_add_sub_man_align;

    localparam int W = 27;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, o_ready, i_sign, i_eff_sub, o_valid, i_ready, o_sign, o_eff_sub;
    logic [23:0] i_man_min, i_man_max;
    logic [7:0]  i_exp_diff, i_exp_max, o_exp_max;
    logic [26:0] o_man_max, o_man_min;

    add_sub_man_align #(.SIZE_MAN(24), .SIZE_EXP(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_man_min(i_man_min), .i_man_max(i_man_max), .i_exp_diff(i_exp_diff),
        .i_exp_max(i_exp_max), .i_sign(i_sign), .i_eff_sub(i_eff_sub),
        .o_valid(o_valid), .i_ready(i_ready), .o_man_max(o_man_max), .o_man_min(o_man_min),
        .o_exp_max(o_exp_max), .o_sign(o_sign), .o_eff_sub(o_eff_sub)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [23:0] mn;
        logic [7:0]  d;
        logic [26:0] exp_mn;
    } vec_t;

    typedef struct {
        logic [26:0] mx;
        logic [26:0] mn;
        logic [7:0]  ex;
        logic        sg;
        logic        es;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    int   n_acc, run, max_run;
    logic last_ready, last_acc;
    logic [63:0] last_out, snap;
    vec_t vecs[10];

    function automatic logic [26:0] ref_align(input logic [23:0] m, input logic [7:0] d);
        logic [26:0] e, r;
        logic        st;
        e = {m, 3'b000};
        if (int'(d) >= W) return {26'd0, |m};
        r  = e >> d;
        st = 1'b0;
        for (int i = 0; i < int'(d); i++) st = st | e[i];
        r[0] = r[0] | st;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drive_rand();
        i_man_min  = ($urandom_range(15) == 0) ? 24'h000000 : 24'($urandom);
        i_man_max  = 24'($urandom);
        i_exp_diff = ($urandom_range(1) == 1) ? 8'($urandom_range(31)) : 8'($urandom_range(255));
        i_exp_max  = 8'($urandom);
        i_sign     = 1'($urandom_range(1));
        i_eff_sub  = 1'($urandom_range(1));
    endtask

    // One clock cycle with scoreboard tracking; inputs are set by the caller at the negedge.
    task automatic cycle();
        out_t e;
        #1;
        last_ready = o_ready;
        last_out   = {o_man_max, o_man_min, o_exp_max, o_sign, o_eff_sub};
        last_acc   = i_valid && o_ready;
        run        = o_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("set", last_out, {e.mx, e.mn, e.ex, e.sg, e.es});
            end
        end
        if (last_acc) begin
            sb.push_back('{{i_man_max, 3'b000}, ref_align(i_man_min, i_exp_diff), i_exp_max, i_sign, i_eff_sub});
            n_acc++;
        end
        tick();
    endtask

    initial begin
        vecs[0] = '{24'h800000, 8'd0,   27'h4000000};
        vecs[1] = '{24'h800000, 8'd1,   27'h2000000};
        vecs[2] = '{24'h800000, 8'd25,  27'h0000002};
        vecs[3] = '{24'h800000, 8'd26,  27'h0000001};
        vecs[4] = '{24'h800000, 8'd27,  27'h0000001};
        vecs[5] = '{24'h800000, 8'd255, 27'h0000001};
        vecs[6] = '{24'h800001, 8'd4,   27'h0400001};
        vecs[7] = '{24'h800001, 8'd3,   27'h0800001};
        vecs[8] = '{24'h800003, 8'd6,   27'h0100001};
        vecs[9] = '{24'h000000, 8'd255, 27'h0000000};

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_man_min = 24'd0; i_man_max = 24'd0; i_exp_diff = 8'd0; i_exp_max = 8'd0;
        i_sign = 1'b0; i_eff_sub = 1'b0;
        n_acc = 0; run = 0; max_run = 0; last_ready = 1'b0; last_acc = 1'b0;
        last_out = 64'd0; snap = 64'd0;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_data", {o_man_max, o_man_min, o_exp_max, o_sign, o_eff_sub}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed table: one set at a time, latency and every field checked.
        for (int k = 0; k < 10; k++) begin
            i_man_min  = vecs[k].mn;
            i_man_max  = 24'hA00000 + 24'(k);
            i_exp_diff = vecs[k].d;
            i_exp_max  = 8'(8'd100 + 8'(k));
            i_sign     = 1'(k % 2);
            i_eff_sub  = 1'(k % 3 == 0);
            i_valid    = 1'b1;
            #1;
            check("ready_idle", 64'(o_ready), 64'd1);
            tick();
            i_valid = 1'b0;
            #1;
            check("lat1_valid", 64'(o_valid), 64'd0);
            tick();
            #1;
            check("lat2_valid", 64'(o_valid), 64'd1);
            check("man_min", 64'(o_man_min), 64'(vecs[k].exp_mn));
            check("man_max", 64'(o_man_max), 64'({24'hA00000 + 24'(k), 3'b000}));
            check("pass", {54'd0, o_exp_max, o_sign, o_eff_sub},
                  {54'd0, 8'(8'd100 + 8'(k)), 1'(k % 2), 1'(k % 3 == 0)});
            tick();
        end

        // Back-to-back stream of 8 sets.
        i_ready = 1'b1; max_run = 0; run = 0;
        for (int k = 0; k < 8; k++) begin
            drive_rand();
            i_valid = 1'b1;
            cycle();
        end
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        check("stream_run", 64'(max_run), 64'd8);
        check("stream_empty", 64'(sb.size()), 64'd0);

        // Stall: three cycles with i_ready low, o_ready must read 1,1,0.
        i_ready = 1'b0;
        drive_rand(); i_valid = 1'b1;
        cycle();
        check("stall_rdy1", 64'(last_ready), 64'd1);
        drive_rand();
        cycle();
        check("stall_rdy2", 64'(last_ready), 64'd1);
        drive_rand();
        cycle();
        check("stall_rdy3", 64'(last_ready), 64'd0);
        snap = last_out;
        i_ready = 1'b1;
        cycle();
        check("stall_hold", last_out, snap);
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        check("stall_empty", 64'(sb.size()), 64'd0);

        // Reset with both stages full.
        i_ready = 1'b0;
        drive_rand(); i_man_min = 24'hFFFFFF; i_exp_diff = 8'd2; i_valid = 1'b1;
        cycle();
        drive_rand(); i_man_min = 24'h123456; i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        #2;
        check("pre_rst_valid", 64'(o_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_data", {o_man_max, o_man_min, o_exp_max, o_sign, o_eff_sub}, 64'd0);
        sb.delete();
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_man_min = 24'h800001; i_man_max = 24'h555555; i_exp_diff = 8'd4;
        i_exp_max = 8'h7E; i_sign = 1'b1; i_eff_sub = 1'b1; i_valid = 1'b1;
        n_acc = 0;
        cycle();
        i_valid = 1'b0;
        #1;
        check("post_rst_lat1", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        #1;
        check("post_rst_set", {o_man_max, o_man_min, o_exp_max, o_sign, o_eff_sub},
              {27'h2AAAAA8, 27'h0400001, 8'h7E, 1'b1, 1'b1});
        @(negedge i_clk);
        sb.delete();

        // Random valid/ready toggling, holding inputs stable while stalled.
        n_acc = 0; last_acc = 1'b0; last_ready = 1'b1;
        for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
            if (!(i_valid && !last_acc)) begin
                drive_rand();
                i_valid = ($urandom_range(3) != 0);
            end
            i_ready = ($urandom_range(3) != 0);
            cycle();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        check("rand_accepts", 64'(n_acc), 64'd10000);
        check("rand_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
